instr_fetch: RTL

Fetch stage that sits directly downstream of the 5-bit program counter. It samples the counter value, reads a loadable 32x8 instruction memory, and presents the instruction on a valid/ready handshake. Accepted jump instructions drive jump_en/jump_off, which connect to the counter's enable/num_up inputs so the counter adds the offset instead of incrementing.

---
 rtl/instr_fetch.sv | 110 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: samples the program counter, reads a loadable instruction memory
// and presents the instruction on a valid/ready handshake with jump feedback.
module instr_fetch #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] pc,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              jump_en,
    output logic [ADDR_W-1:0] jump_off,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              load_addr;
    logic              load_instr;
    logic              accept;
    logic              take_jump;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = READ;
            READ:    state_nxt = VALID;
            VALID:   if (instr_ready) state_nxt = run ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // run is only consulted when a fetch may start; an in-flight fetch always completes.
    always_comb begin
        accept     = (state == VALID) && instr_ready;
        load_addr  = ((state == IDLE) && run) || (accept && run);
        load_instr = (state == READ);
        take_jump  = accept && instr[DATA_W-1];
        busy       = (state != IDLE);
    end

    // Memory is never reset; program contents survive RST_N.
    always_ff @(posedge CLK) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q <= '0;
        end else if (load_addr) begin
            addr_q <= pc;
        end
    end

    // Non-blocking read of mem on the same edge as a write gives read-before-write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            instr       <= '0;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
        end else if (load_instr) begin
            instr       <= mem[addr_q];
            instr_addr  <= addr_q;
            instr_valid <= 1'b1;
        end else if (accept) begin
            instr_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            jump_en  <= 1'b0;
            jump_off <= '0;
        end else begin
            jump_en <= take_jump;
            if (take_jump) begin
                jump_off <= instr[ADDR_W-1:0];
            end
        end
    end

endmodule
